fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the immediate sign-extender: owns the PC, drives the instruction-memory address, and registers the fetched word into the IF/ID register. That register feeds the decoder and the sign-extender. Consumes the extended immediate back from the sign-extender to form branch targets (PC_ID + imm). Adds a small boot/run/halt FSM with stall, flush and halt handling.

Parameters:
WIDTH, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
stall_i  input  1  hazard stall; hold PC and IF/ID register
branch_taken_i  input  1  branch/jump resolved taken for the instruction currently in IF/ID
imm_ext_i  input  WIDTH  sign-extended immediate of the IF/ID instruction (from sign-extender)
imem_rdata_i  input  WIDTH  instruction word at imem_addr_o (combinational read)
imem_addr_o  output  WIDTH  fetch address (= pc_q)
instr_o  output  WIDTH  IF/ID instruction (feeds decoder and sign-extender)
pc_id_o  output  WIDTH  PC of instr_o
valid_o  output  1  instr_o is a real instruction, not a bubble
halted_o  output  1  FSM in HALT
misalign_o  output  1  sticky: halted on a misaligned branch target

Behaviour:
- Reset (rst_n low, async): state=BOOT, pc_q=RESET_PC, instr_o=NOP (32'h0000_0013), pc_id_o=0, valid_o=0, halted_o=0, misalign_o=0.
- The reset assertion mid-operation discards all state immediately. No pending branch survives.
- FSM states: BOOT, RUN, HALT.
- BOOT: lasts exactly one clock edge after rst_n rises. Nothing is captured. Next state is RUN.
- RUN, edge with stall_i=0 and no taken branch:
  - instr_o <= imem_rdata_i, pc_id_o <= pc_q, valid_o <= 1.
  - pc_q <= pc_q + 4 (mod 2^WIDTH; wrap from FFFF_FFFC to 0 is allowed, with no flag).
- RUN, taken branch (branch_taken_i=1 and valid_o=1):
  - target = pc_id_o + imm_ext_i (WIDTH-bit add, overflow discarded).
  - If target[1:0]==0: pc_q <= target, instr_o <= NOP, valid_o <= 0. This is a one-cycle flush of the wrong-path fetch.
  - If target[1:0]!=0: state <= HALT, misalign_o <= 1, pc_q unchanged, instr_o <= NOP, valid_o <= 0.
- branch_taken_i is ignored when valid_o=0.
- Priority: a taken branch overrides stall_i. Stall only holds sequential fetch.
- RUN, stall_i=1 and no taken branch: pc_q, instr_o, pc_id_o and valid_o are all held.
- Halt detect: on a RUN edge where valid_o=1, instr_o==32'h0000_0073 (ECALL), branch_taken_i=0 and stall_i=0:
  - state <= HALT, instr_o <= NOP, valid_o <= 0, pc_q held.
- HALT: halted_o=1, valid_o=0, pc_q frozen, all inputs ignored. Only reset exits.
- halted_o is a registered output (state==HALT).
- imem_addr_o = pc_q in every state.
- Latency:
  - First valid_o=1 appears after the 2nd rising edge following rst_n deassertion, carrying the word at RESET_PC.
  - Branch-taken penalty is 1 bubble cycle.

Decomposition:
- Package fetch_pkg:
  - typedef enum logic [1:0] fetch_state_t {BOOT, RUN, HALT}
  - NOP_INSTR = 32'h0000_0013
  - ECALL_INSTR = 32'h0000_0073
  - PC_STEP = 4
- One sub-module, pc_next: combinational unit computing target and the misaligned flag, plus the next-PC mux (pc+4 / target / hold).
- The FSM and the IF/ID register stay in fetch_stage.

Test Plan:
- Reset release, imem returns addr-as-data, no stall:
  - Edge 1: valid_o=0.
  - Edge 2: instr_o=0x0, pc_id_o=0, valid_o=1.
  - Edge 3: pc_id_o=4.
  - Throughout, imem_addr_o steps 0,4,8,...
- Stall_i=1 for 3 cycles at pc_q=0x10: imem_addr_o, instr_o and pc_id_o are held for 3 cycles. Fetch resumes at 0x10.
- Taken branch, pc_id_o=0x8, imm_ext_i=32'hFFFF_FFF8, concurrent stall_i=1:
  - Next edge: pc_q=0x0, valid_o=0.
  - Following edge: instr_o=mem[0], valid_o=1.
- Taken branch with target 0x0A (pc_id_o=0x8, imm=2): HALT, misalign_o=1, halted_o=1, pc frozen, valid_o stays 0 for 10 cycles.
- ECALL fetched at 0x14 with stall_i=0: one edge after valid_o=1 with instr_o=0x73, halted_o=1 and valid_o=0. Then reset → BOOT with all outputs at reset values.
- rst_n pulsed low mid-RUN at pc_q=0x40, asynchronously between edges: outputs go to reset values immediately without a clock edge. Restart is at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;
  localparam int unsigned PC_STEP     = 4;

endpackage

// File: rtl/fetch_stage_pc_next.sv
// Next-PC selection: branch target (PC_ID + imm), sequential PC + 4, or hold.
module pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] pc_id_i,
  input  logic [WIDTH-1:0] imm_ext_i,
  input  logic             take_i,
  input  logic             adv_i,
  output logic [WIDTH-1:0] pc_next_o,
  output logic             misalign_o
);

  logic [WIDTH-1:0] target;

  always_comb begin
    target     = pc_id_i + imm_ext_i;
    misalign_o = |target[1:0];
    pc_next_o  = pc_i;
    // A misaligned taken target leaves the PC untouched; the FSM halts instead.
    if (take_i) begin
      if (!misalign_o) pc_next_o = target;
    end else if (adv_i) begin
      pc_next_o = pc_i + WIDTH'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register and BOOT/RUN/HALT control.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] imm_ext_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic [WIDTH-1:0] imem_addr_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_id_o,
  output logic             valid_o,
  output logic             halted_o,
  output logic             misalign_o
);

  fetch_state_t     state_q;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, pc_id_q;
  logic             valid_q, halted_q, misalign_q;
  logic             run, take, is_ecall, adv, tgt_misalign;

  always_comb begin
    run      = (state_q == RUN);
    take     = run && branch_taken_i && valid_q;
    is_ecall = valid_q && (instr_q == WIDTH'(ECALL_INSTR));
    adv      = run && !take && !stall_i && !is_ecall;
  end

  pc_next #(.WIDTH(WIDTH)) u_pc_next (
    .pc_i       (pc_q),
    .pc_id_i    (pc_id_q),
    .imm_ext_i  (imm_ext_i),
    .take_i     (take),
    .adv_i      (adv),
    .pc_next_o  (pc_d),
    .misalign_o (tgt_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= WIDTH'(NOP_INSTR);
      pc_id_q    <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          pc_q <= pc_d;
          // Taken branch wins over stall; the wrong-path fetch becomes a bubble.
          if (take) begin
            instr_q <= WIDTH'(NOP_INSTR);
            valid_q <= 1'b0;
            if (tgt_misalign) begin
              state_q    <= HALT;
              halted_q   <= 1'b1;
              misalign_q <= 1'b1;
            end
          end else if (!stall_i) begin
            if (is_ecall) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
              instr_q  <= WIDTH'(NOP_INSTR);
              valid_q  <= 1'b0;
            end else begin
              instr_q <= imem_rdata_i;
              pc_id_q <= pc_q;
              valid_q <= 1'b1;
            end
          end
        end
        HALT: ;
        default: state_q <= BOOT;
      endcase
    end
  end

  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_id_o     = pc_id_q;
  assign valid_o     = valid_q;
  assign halted_o    = halted_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; imem returns address as data.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] rdata;
  logic [31:0] addr, instr, pcid;
  logic        valid, halted, misal;
  logic        ecall_en = 1'b1;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  // Word at 0x14 is ECALL when enabled, every other word equals its address.
  assign rdata = (ecall_en && addr == 32'h14) ? 32'h0000_0073 : addr;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall),
    .branch_taken_i (br),
    .imm_ext_i      (imm),
    .imem_rdata_i   (rdata),
    .imem_addr_o    (addr),
    .instr_o        (instr),
    .pc_id_o        (pcid),
    .valid_o        (valid),
    .halted_o       (halted),
    .misalign_o     (misal)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] imm;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcid;
    logic        valid;
    logic        halted;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic b, input logic [31:0] im);
    stall = s;
    br    = b;
    imm   = im;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".addr"},   addr,   32'h0);
    chk({tag, ".instr"},  instr,  32'h13);
    chk({tag, ".pcid"},   pcid,   32'h0);
    chk({tag, ".valid"},  32'(valid),  32'h0);
    chk({tag, ".halted"}, 32'(halted), 32'h0);
    chk({tag, ".misal"},  32'(misal),  32'h0);
  endtask

  // Asserts reset between edges, checks outputs before any edge, releases on a negedge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals(tag);
    stall = 1'b0;
    br    = 1'b0;
    imm   = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 32'h0,         32'h00, 32'h13, 32'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         32'h04, 32'h00, 32'h00, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         32'h08, 32'h04, 32'h04, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,         32'h0C, 32'h08, 32'h08, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 32'hFFFF_FFF8, 32'h00, 32'h13, 32'h08, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'h100,       32'h04, 32'h00, 32'h00, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         32'h08, 32'h04, 32'h04, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,         32'h0C, 32'h08, 32'h08, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,         32'h10, 32'h0C, 32'h0C, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,         32'h10, 32'h0C, 32'h0C, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'h0,         32'h10, 32'h0C, 32'h0C, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 32'h0,         32'h10, 32'h0C, 32'h0C, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,         32'h14, 32'h10, 32'h10, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 32'h0,         32'h18, 32'h73, 32'h14, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 32'h0,         32'h18, 32'h73, 32'h14, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 32'h0,         32'h18, 32'h13, 32'h14, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 32'h4,         32'h18, 32'h13, 32'h14, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 32'h0,         32'h18, 32'h13, 32'h14, 1'b0, 1'b1};

    do_reset("rst0");

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].stall, tbl[i].br, tbl[i].imm);
      chk($sformatf("v%0d.addr", i),   addr,          tbl[i].addr);
      chk($sformatf("v%0d.instr", i),  instr,         tbl[i].instr);
      chk($sformatf("v%0d.pcid", i),   pcid,          tbl[i].pcid);
      chk($sformatf("v%0d.valid", i),  32'(valid),    32'(tbl[i].valid));
      chk($sformatf("v%0d.halted", i), 32'(halted),   32'(tbl[i].halted));
      chk($sformatf("v%0d.misal", i),  32'(misal),    32'h0);
    end

    do_reset("rst_after_ecall");
    ecall_en = 1'b0;

    // PC wrap: branch to 0xFFFF_FFFC, then sequential fetch wraps to 0.
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap.pcid0", pcid, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap.br_addr", addr, 32'hFFFF_FFFC);
    chk("wrap.br_valid", 32'(valid), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap.instr", instr, 32'hFFFF_FFFC);
    chk("wrap.pcid", pcid, 32'hFFFF_FFFC);
    chk("wrap.addr0", addr, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap.pcid_after", pcid, 32'h0);
    chk("wrap.addr4", addr, 32'h4);

    do_reset("rst_after_wrap");

    // Misaligned taken branch halts with the PC frozen.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    chk("mis.pcid8", pcid, 32'h8);
    chk("mis.addrC", addr, 32'hC);
    step(1'b0, 1'b1, 32'h2);
    chk("mis.halted", 32'(halted), 32'h1);
    chk("mis.flag", 32'(misal), 32'h1);
    chk("mis.addr", addr, 32'hC);
    chk("mis.valid", 32'(valid), 32'h0);
    chk("mis.instr", instr, 32'h13);
    for (int i = 0; i < 10; i++) begin
      step(1'(i % 2), 1'b1, 32'h0);
      chk($sformatf("mis.h%0d.valid", i),  32'(valid),  32'h0);
      chk($sformatf("mis.h%0d.addr", i),   addr,        32'hC);
      chk($sformatf("mis.h%0d.halted", i), 32'(halted), 32'h1);
      chk($sformatf("mis.h%0d.flag", i),   32'(misal),  32'h1);
    end

    do_reset("rst_after_mis");

    // Asynchronous reset mid-run at pc 0x40, taken between clock edges.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 32'h0);
    chk("async.pre_addr", addr, 32'h40);
    chk("async.pre_valid", 32'(valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    chk("async.e1_valid", 32'(valid), 32'h0);
    chk("async.e1_addr", addr, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("async.e2_valid", 32'(valid), 32'h1);
    chk("async.e2_instr", instr, 32'h0);
    chk("async.e2_pcid", pcid, 32'h0);
    chk("async.e2_addr", addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
